// File: rtl/radix3_input_collector_if.sv
// Stream interface for the radix-3 input collector: sample input and a/b/c triple output.
// RADIX3_COLLECT_FRAMECNT_EN adds the out_frame signal.
interface radix3_input_collector_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_img;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] a_re;
  logic [DW-1:0] a_img;
  logic [DW-1:0] b_re;
  logic [DW-1:0] b_img;
  logic [DW-1:0] c_re;
  logic [DW-1:0] c_img;
  logic          out_last;
`ifdef RADIX3_COLLECT_FRAMECNT_EN
  logic [7:0]    out_frame;

  modport master (
    output in_valid, in_re, in_img, out_ready,
    input  in_ready, out_valid, a_re, a_img, b_re, b_img, c_re, c_img, out_last, out_frame
  );

  modport slave (
    input  in_valid, in_re, in_img, out_ready,
    output in_ready, out_valid, a_re, a_img, b_re, b_img, c_re, c_img, out_last, out_frame
  );
`else
  modport master (
    output in_valid, in_re, in_img, out_ready,
    input  in_ready, out_valid, a_re, a_img, b_re, b_img, c_re, c_img, out_last
  );

  modport slave (
    input  in_valid, in_re, in_img, out_ready,
    output in_ready, out_valid, a_re, a_img, b_re, b_img, c_re, c_img, out_last
  );
`endif
endinterface

// File: rtl/radix3_input_collector.sv
// Ping-pong frame buffer feeding stride-M triples (x[k], x[k+M], x[k+2M]) to a radix-3 butterfly.
// Optional frame index output enabled by RADIX3_COLLECT_FRAMECNT_EN.
module radix3_input_collector #(
  parameter int DW = 32,
  parameter int M  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  radix3_input_collector_if.slave  bus
);

  localparam int N  = 3 * M;
  localparam int AW = $clog2(N);

  localparam logic [AW-1:0] A_LAST = AW'(N - 1);
  localparam logic [AW-1:0] K_LAST = AW'(M - 1);
  localparam logic [AW-1:0] A_M    = AW'(M);
  localparam logic [AW-1:0] A_2M   = AW'(2 * M);

  localparam logic [0:0] WR_FILL = 1'b0;
  localparam logic [0:0] WR_HOLD = 1'b1;
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_EMIT = 1'b1;

  // Bank b occupies entries [b*N, b*N+N-1]; each entry is {re, img}.
  logic [2*DW-1:0] r_mem [2*N];

  logic [0:0]    r_wr_state;
  logic [0:0]    r_rd_state;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [AW-1:0] r_wr_cnt;
  logic [AW-1:0] r_rd_cnt;
  logic          r_out_valid;
  logic          r_out_last;
  logic [DW-1:0] r_a_re;
  logic [DW-1:0] r_a_img;
  logic [DW-1:0] r_b_re;
  logic [DW-1:0] r_b_img;
  logic [DW-1:0] r_c_re;
  logic [DW-1:0] r_c_img;

  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_rd_final;
  logic            w_rd_free;
  logic            w_wr_last;
  logic            w_swap;
  logic            w_load;
  logic            w_ld_bank;
  logic [AW-1:0]   w_ld_k;
  logic [AW-1:0]   w_adr_a;
  logic [AW-1:0]   w_adr_b;
  logic [AW-1:0]   w_adr_c;
  logic            w_byp;
  logic [2*DW-1:0] w_in_word;
  logic [2*DW-1:0] w_ta;
  logic [2*DW-1:0] w_tb;
  logic [2*DW-1:0] w_tc;

  function automatic logic [AW:0] f_idx(input logic bank, input logic [AW-1:0] addr);
    return bank ? ((AW+1)'(N) + {1'b0, addr}) : {1'b0, addr};
  endfunction

  always_comb begin
    w_in_fire  = bus.in_valid & (r_wr_state == WR_FILL);
    w_out_fire = r_out_valid & bus.out_ready;
    w_rd_final = w_out_fire & (r_rd_cnt == K_LAST);
    w_rd_free  = (r_rd_state == RD_IDLE) | w_rd_final;
    w_wr_last  = w_in_fire & (r_wr_cnt == A_LAST);
    w_swap     = (w_wr_last & w_rd_free) |
                 ((r_wr_state == WR_HOLD) & (r_rd_state == RD_IDLE));
    w_load     = w_swap | (w_out_fire & ~w_rd_final);
    w_ld_bank  = w_swap ? r_wr_bank : r_rd_bank;
    w_ld_k     = w_swap ? '0 : (r_rd_cnt + 1'b1);
    w_adr_a    = w_ld_k;
    w_adr_b    = w_ld_k + A_M;
    w_adr_c    = w_ld_k + A_2M;
    w_in_word  = {bus.in_re, bus.in_img};
    // The frame's final sample is still in flight when triple 0 loads on a swap.
    w_byp      = w_in_fire & (w_ld_bank == r_wr_bank);
    w_ta       = (w_byp && (w_adr_a == r_wr_cnt)) ? w_in_word : r_mem[f_idx(w_ld_bank, w_adr_a)];
    w_tb       = (w_byp && (w_adr_b == r_wr_cnt)) ? w_in_word : r_mem[f_idx(w_ld_bank, w_adr_b)];
    w_tc       = (w_byp && (w_adr_c == r_wr_cnt)) ? w_in_word : r_mem[f_idx(w_ld_bank, w_adr_c)];
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_mem[f_idx(r_wr_bank, r_wr_cnt)] <= w_in_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_state  <= WR_FILL;
      r_rd_state  <= RD_IDLE;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_a_re      <= '0;
      r_a_img     <= '0;
      r_b_re      <= '0;
      r_b_img     <= '0;
      r_c_re      <= '0;
      r_c_img     <= '0;
    end else begin
      if (w_in_fire) begin
        r_wr_cnt <= w_wr_last ? '0 : (r_wr_cnt + 1'b1);
      end

      if (w_swap) begin
        r_wr_bank  <= ~r_wr_bank;
        r_wr_state <= WR_FILL;
      end else if (w_wr_last) begin
        r_wr_state <= WR_HOLD;
      end

      if (w_swap) begin
        r_rd_state  <= RD_EMIT;
        r_rd_bank   <= r_wr_bank;
        r_rd_cnt    <= '0;
        r_out_valid <= 1'b1;
      end else if (w_rd_final) begin
        r_rd_state  <= RD_IDLE;
        r_rd_cnt    <= '0;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else if (w_out_fire) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end

      if (w_load) begin
        {r_a_re, r_a_img} <= w_ta;
        {r_b_re, r_b_img} <= w_tb;
        {r_c_re, r_c_img} <= w_tc;
        r_out_last        <= (w_ld_k == K_LAST);
      end
    end
  end

`ifdef RADIX3_COLLECT_FRAMECNT_EN
  logic [7:0] r_frame;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame <= '0;
    end else if (w_out_fire && r_out_last) begin
      r_frame <= r_frame + 8'd1;
    end
  end

  assign bus.out_frame = r_frame;
`endif

  assign bus.in_ready  = (r_wr_state == WR_FILL);
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.a_re      = r_a_re;
  assign bus.a_img     = r_a_img;
  assign bus.b_re      = r_b_re;
  assign bus.b_img     = r_b_img;
  assign bus.c_re      = r_c_re;
  assign bus.c_img     = r_c_img;

endmodule
